// File: rtl/rou_axi_rd_tracker.sv
// AXI read-burst tracker: AR -> slot + registered ring request (1 cycle); ring beats -> AXI R register (1 cycle).
// Backpressure: arready drops when no slot is free, the id is in flight, or the request register is stalled; resp_ready follows R.
module rou_axi_rd_tracker #(
  parameter int DWID  = 128,
  parameter int AWID  = 32,
  parameter int IDWID = 4,
  parameter int NSLOT = 4,
  parameter int SLOTW = 2,
  parameter int BWID  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDWID-1:0]   arid,
  input  logic [AWID-1:0]    araddr,
  input  logic [7:0]         arlen,
  input  logic [2:0]         arsize,
  input  logic               arvalid,
  output logic               arready,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [AWID-1:0]    req_addr,
  output logic [15:0]        req_bytes,
  output logic [SLOTW-1:0]   req_tag,
  input  logic               resp_valid,
  output logic               resp_ready,
  input  logic [SLOTW-1:0]   resp_tag,
  input  logic [DWID-1:0]    resp_data,
  input  logic [BWID:0]      resp_bytes,
  output logic [IDWID-1:0]   rid,
  output logic [DWID-1:0]    rdata,
  output logic               rlast,
  output logic               rvalid,
  input  logic               rready,
  output logic [SLOTW:0]     busy,
  output logic               err_stray,
  output logic               err_size
);

  logic [NSLOT-1:0] active;
  logic [IDWID-1:0] slot_id   [NSLOT];
  logic [16:0]      remaining [NSLOT];

  logic             any_free;
  logic             id_hit;
  logic [SLOTW-1:0] free_idx;
  logic             ar_fire;
  logic             size_clamp;
  logic [2:0]       eff_size;
  logic [16:0]      burst_bytes;
  logic             resp_fire;
  logic             resp_hit;
  logic [16:0]      beat_bytes;
  logic [16:0]      sel_rem;
  logic             beat_last;
  logic [16:0]      rem_next;
  logic             free_now;
  logic [NSLOT-1:0] free_mask;
  logic [NSLOT-1:0] alloc_mask;
  logic [NSLOT-1:0] next_active;
  logic [SLOTW:0]   busy_next;

  // Allocation only looks at registered slot state, so a slot freed this cycle is usable next cycle.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    id_hit   = 1'b0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!active[i]) begin
        any_free = 1'b1;
        free_idx = SLOTW'(i);
      end
    end
    for (int i = 0; i < NSLOT; i++) begin
      if (active[i] && slot_id[i] == arid) id_hit = 1'b1;
    end
  end

  assign arready     = any_free && !id_hit && (!req_valid || req_ready);
  assign ar_fire     = arvalid && arready;
  assign size_clamp  = arsize > 3'(BWID);
  assign eff_size    = size_clamp ? 3'(BWID) : arsize;
  assign burst_bytes = (17'(arlen) + 17'd1) << eff_size;

  assign resp_ready = !rvalid || rready;
  assign resp_fire  = resp_valid && resp_ready;
  assign resp_hit   = active[resp_tag];
  assign beat_bytes = 17'(resp_bytes);
  assign sel_rem    = remaining[resp_tag];
  assign beat_last  = beat_bytes >= sel_rem;
  assign rem_next   = beat_last ? 17'd0 : sel_rem - beat_bytes;

  assign free_now = rvalid && rready && rlast;

  always_comb begin
    free_mask  = '0;
    alloc_mask = '0;
    busy_next  = '0;
    for (int i = 0; i < NSLOT; i++) begin
      free_mask[i]  = free_now && active[i] && (slot_id[i] == rid);
      alloc_mask[i] = ar_fire && (free_idx == SLOTW'(i));
    end
    next_active = (active & ~free_mask) | alloc_mask;
    for (int i = 0; i < NSLOT; i++) begin
      busy_next = busy_next + (SLOTW+1)'(next_active[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        slot_id[i]   <= '0;
        remaining[i] <= '0;
      end
    end else begin
      active <= next_active;
      for (int i = 0; i < NSLOT; i++) begin
        if (alloc_mask[i]) begin
          slot_id[i]   <= arid;
          remaining[i] <= burst_bytes;
        end else if (resp_fire && resp_hit && resp_tag == SLOTW'(i)) begin
          remaining[i] <= rem_next;
        end
      end
    end
  end

  // Request register reloads directly on a back-to-back accept, so there is no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_bytes <= '0;
      req_tag   <= '0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rid       <= '0;
      rdata     <= '0;
      busy      <= '0;
      err_stray <= 1'b0;
      err_size  <= 1'b0;
    end else begin
      if (ar_fire) begin
        req_valid <= 1'b1;
        req_addr  <= araddr;
        req_bytes <= burst_bytes[15:0];
        req_tag   <= free_idx;
      end else if (req_ready) begin
        req_valid <= 1'b0;
      end
      if (resp_fire && resp_hit) begin
        rvalid <= 1'b1;
        rdata  <= resp_data;
        rid    <= slot_id[resp_tag];
        rlast  <= beat_last;
      end else if (rready) begin
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end
      busy      <= busy_next;
      err_stray <= resp_fire && !resp_hit;
      err_size  <= ar_fire && size_clamp;
    end
  end

endmodule

// File: tb/tb_rou_axi_rd_tracker.sv
// Bench for rou_axi_rd_tracker: directed scenarios plus random traffic against a slot-level reference model.
module tb_rou_axi_rd_tracker;
  localparam int DWID = 128, AWID = 32, IDWID = 4, NSLOT = 4, SLOTW = 2, BWID = 4;
  localparam int MAXB = DWID / 8;

  logic clk, rst_n;
  logic [IDWID-1:0] arid;
  logic [AWID-1:0]  araddr;
  logic [7:0]       arlen;
  logic [2:0]       arsize;
  logic             arvalid, arready;
  logic             req_valid, req_ready;
  logic [AWID-1:0]  req_addr;
  logic [15:0]      req_bytes;
  logic [SLOTW-1:0] req_tag;
  logic             resp_valid, resp_ready;
  logic [SLOTW-1:0] resp_tag;
  logic [DWID-1:0]  resp_data;
  logic [BWID:0]    resp_bytes;
  logic [IDWID-1:0] rid;
  logic [DWID-1:0]  rdata;
  logic             rlast, rvalid, rready;
  logic [SLOTW:0]   busy;
  logic             err_stray, err_size;

  rou_axi_rd_tracker #(.DWID(DWID), .AWID(AWID), .IDWID(IDWID), .NSLOT(NSLOT), .SLOTW(SLOTW), .BWID(BWID)) dut (
    .clk(clk), .rst_n(rst_n),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_bytes(req_bytes), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag), .resp_data(resp_data), .resp_bytes(resp_bytes),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .busy(busy), .err_stray(err_stray), .err_size(err_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: which slots hold which burst, and how many bytes each still owes.
  bit          m_act [NSLOT];
  int          m_id  [NSLOT];
  int          m_rem [NSLOT];
  bit          m_req_vld;
  logic [31:0] m_req_addr;
  int          m_req_bytes, m_req_tag;
  bit          m_rvld, m_rlast, m_err_stray, m_err_size;
  logic [127:0] m_rdata;
  int          m_rid;
  int          ring_left [NSLOT];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_free_slot();
    for (int i = 0; i < NSLOT; i++) if (!m_act[i]) return i;
    return -1;
  endfunction

  function automatic bit m_arready();
    bit hit = 0;
    for (int i = 0; i < NSLOT; i++) if (m_act[i] && m_id[i] == int'(arid)) hit = 1;
    return (m_free_slot() >= 0) && !hit && (!m_req_vld || req_ready);
  endfunction

  function automatic int m_busy();
    int n = 0;
    for (int i = 0; i < NSLOT; i++) n += int'(m_act[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NSLOT; i++) begin
      m_act[i] = 0; m_id[i] = 0; m_rem[i] = 0; ring_left[i] = 0;
    end
    m_req_vld = 0; m_req_addr = 0; m_req_bytes = 0; m_req_tag = 0;
    m_rvld = 0; m_rlast = 0; m_rdata = 0; m_rid = 0; m_err_stray = 0; m_err_size = 0;
  endtask

  task automatic compare();
    chk("arready", arready, m_arready());
    chk("resp_ready", resp_ready, !m_rvld || rready);
    chk("req_valid", req_valid, m_req_vld);
    if (m_req_vld) begin
      chk("req_addr", req_addr, m_req_addr);
      chk("req_bytes", req_bytes, m_req_bytes);
      chk("req_tag", req_tag, m_req_tag);
    end
    chk("rvalid", rvalid, m_rvld);
    if (m_rvld) begin
      chk("rid", rid, m_rid);
      chk("rdata", rdata, m_rdata);
      chk("rlast", rlast, m_rlast);
    end
    chk("busy", busy, m_busy());
    chk("err_stray", err_stray, m_err_stray);
    chk("err_size", err_size, m_err_size);
  endtask

  // Advance the model by one clock edge using the inputs presented this cycle.
  task automatic model_update();
    bit arh, rsh, rh, reqh, tag_act;
    int f, rem, bb, sz, nb;
    arh     = arvalid && m_arready();
    f       = m_free_slot();
    rsh     = resp_valid && (!m_rvld || rready);
    rh      = m_rvld && rready;
    reqh    = m_req_vld && req_ready;
    tag_act = m_act[resp_tag];
    rem     = m_rem[resp_tag];
    bb      = int'(resp_bytes);
    if (reqh) ring_left[m_req_tag] = m_req_bytes;
    if (rh && m_rlast)
      for (int i = 0; i < NSLOT; i++) if (m_act[i] && m_id[i] == m_rid) m_act[i] = 0;
    if (arh) begin
      sz = (arsize > 4) ? 4 : int'(arsize);
      nb = (int'(arlen) + 1) << sz;
      m_act[f] = 1; m_id[f] = arid; m_rem[f] = nb;
      m_req_vld = 1; m_req_addr = araddr; m_req_bytes = nb; m_req_tag = f;
    end else if (reqh) begin
      m_req_vld = 0;
    end
    m_err_size  = arh && (arsize > 4);
    m_err_stray = rsh && !tag_act;
    if (rsh && tag_act) begin
      m_rvld = 1; m_rdata = resp_data; m_rid = m_id[resp_tag];
      m_rlast = bb >= rem;
      m_rem[resp_tag] = (rem > bb) ? rem - bb : 0;
      ring_left[resp_tag] = (ring_left[resp_tag] > bb) ? ring_left[resp_tag] - bb : 0;
    end else if (rh) begin
      m_rvld = 0;
    end
  endtask

  task automatic tick();
    #1 compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0;
    req_ready = 1; resp_valid = 0; resp_tag = 0; resp_data = 0; resp_bytes = 1; rready = 1;
  endtask

  // Called at a negedge; returns at a later negedge with reset released.
  task automatic do_reset(input string nm);
    rst_n = 0;
    idle_inputs();
    model_clear();
    #1;
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_rvalid"}, rvalid, 0);
    chk({nm, "_rlast"}, rlast, 0);
    chk({nm, "_rid"}, rid, 0);
    chk({nm, "_rdata"}, rdata, 0);
    chk({nm, "_req_valid"}, req_valid, 0);
    chk({nm, "_arready"}, arready, 1);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic rand_inputs();
    int cand [$];
    int t, r;
    arvalid   = ($urandom_range(0, 99) < 50);
    arid      = IDWID'($urandom_range(0, 5));
    araddr    = $urandom;
    arlen     = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 3));
    arsize    = 3'($urandom_range(0, 6));
    req_ready = ($urandom_range(0, 3) != 0);
    rready    = ($urandom_range(0, 9) < 7);
    resp_data = {$urandom, $urandom, $urandom, $urandom};
    resp_valid = 0;
    for (int i = 0; i < NSLOT; i++) if (ring_left[i] > 0) cand.push_back(i);
    r = $urandom_range(0, 99);
    if (cand.size() > 0 && r < 60) begin
      t = cand[$urandom_range(0, cand.size() - 1)];
      resp_valid = 1; resp_tag = SLOTW'(t);
      resp_bytes = (BWID+1)'(($urandom_range(1, MAXB) < ring_left[t]) ? $urandom_range(1, MAXB) : ring_left[t]);
    end else if (r >= 97) begin
      cand.delete();
      for (int i = 0; i < NSLOT; i++) if (!m_act[i] && ring_left[i] == 0) cand.push_back(i);
      if (cand.size() > 0) begin
        resp_valid = 1; resp_tag = SLOTW'(cand[$urandom_range(0, cand.size() - 1)]);
        resp_bytes = (BWID+1)'($urandom_range(1, MAXB));
      end
    end
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    model_clear();
    @(negedge clk);
    do_reset("reset");

    // Single 4-beat burst.
    arvalid = 1; arid = 3; araddr = 32'h1000; arlen = 3; arsize = 4;
    tick();
    arvalid = 0;
    #1;
    chk("single_req_valid", req_valid, 1);
    chk("single_req_bytes", req_bytes, 64);
    chk("single_req_tag", req_tag, 0);
    chk("single_busy", busy, 1);
    tick();
    for (int b = 0; b < 4; b++) begin
      resp_valid = 1; resp_tag = 0; resp_bytes = 16; resp_data = 128'(b + 1);
      tick();
      resp_valid = 0;
      #1;
      chk("single_rid", rid, 3);
      chk("single_rdata", rdata, b + 1);
      chk("single_rlast", rlast, b == 3);
    end
    tick();
    #1 chk("single_busy_end", busy, 0);

    // Oversized arsize is clamped; small partial burst finishes on one 4-byte beat.
    arvalid = 1; arid = 1; arlen = 0; arsize = 6;
    tick();
    arid = 2; arsize = 2;
    #1;
    chk("clamp_err_size", err_size, 1);
    chk("clamp_req_bytes", req_bytes, 16);
    tick();
    arvalid = 0;
    #1 chk("partial_req_bytes", req_bytes, 4);
    tick();
    resp_valid = 1; resp_tag = 1; resp_bytes = 4;
    tick();
    resp_valid = 0;
    #1;
    chk("partial_rid", rid, 2);
    chk("partial_rlast", rlast, 1);
    tick();

    // Fill every slot, then free tag 2 and reuse it.
    do_reset("reset_fill");
    for (int i = 0; i < NSLOT; i++) begin
      arvalid = 1; arid = IDWID'(i); arlen = 0; arsize = 4;
      tick();
    end
    arid = 9;
    #1;
    chk("fill_busy", busy, 4);
    chk("fill_arready", arready, 0);
    arvalid = 0;
    tick();
    resp_valid = 1; resp_tag = 2; resp_bytes = 16;
    tick();
    resp_valid = 0;
    #1;
    chk("fill_rid", rid, 2);
    chk("fill_arready_before_free", arready, 0);
    tick();
    arvalid = 1; arid = 9;
    #1 chk("fill_arready_after_free", arready, 1);
    tick();
    arvalid = 1; arid = 1;
    #1;
    chk("fill_reuse_tag", req_tag, 2);
    chk("same_id_stall", arready, 0);
    arvalid = 0;

    for (int c = 0; c < 1500; c++) begin
      rand_inputs();
      tick();
    end

    // Reset mid-traffic, then a late beat for a now-inactive slot.
    do_reset("reset_mid");
    resp_valid = 1; resp_tag = 3; resp_bytes = 4;
    tick();
    resp_valid = 0;
    #1;
    chk("stray_pulse", err_stray, 1);
    chk("stray_rvalid", rvalid, 0);
    tick();
    #1 chk("stray_pulse_end", err_stray, 0);

    for (int c = 0; c < 1500; c++) begin
      rand_inputs();
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NSLOT; i++) begin
        if (ring_left[i] > 0) begin
          resp_valid = 1; resp_tag = SLOTW'(i);
          resp_bytes = (BWID+1)'((ring_left[i] < MAXB) ? ring_left[i] : MAXB);
        end
      end
      tick();
      resp_valid = 0;
    end
    #1 chk("drain_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
